// File: rtl/wb_dma_copy_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_dma_copy_pkg
//  Description : Shared definitions for the Wishbone memory-to-memory DMA
//                engine: config register indices, CTRL bit positions and the
//                master-side FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_dma_copy_pkg;

    // Config register word indices (s_adr_i)
    localparam logic [1:0] REG_SRC  = 2'd0;
    localparam logic [1:0] REG_DST  = 2'd1;
    localparam logic [1:0] REG_LEN  = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    // CTRL bit positions
    localparam int CTRL_START = 0;   // write: start transfer (self-clearing)
    localparam int CTRL_FILL  = 1;   // r/w  : fill mode
    localparam int CTRL_IE    = 2;   // r/w  : interrupt enable (optional)
    localparam int CTRL_BUSY  = 8;   // read : transfer in progress
    localparam int CTRL_DONE  = 9;   // read : sticky done, write 1 clears
    localparam int CTRL_ERR   = 10;  // read : sticky error, write 1 clears

    // Master FSM states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_RGAP = 3'd2,
        ST_WR   = 3'd3,
        ST_WGAP = 3'd4
    } dma_state_t;

endpackage
`default_nettype wire

// File: rtl/wb_dma_copy_regs.sv
`default_nettype none
// ============================================================================
//  Module      : wb_dma_copy_regs
//  Description : Config slave and register file of the DMA engine.
//                Registered single-cycle ack, SRC/DST/LEN/CTRL registers,
//                sticky DONE/ERR flags and the transfer-progress updates
//                requested by the master FSM.
//  Optional    : WB_DMA_COPY_IRQ_EN adds CTRL.IE and a registered irq level.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                i_s_* / o_s_*   - Wishbone config slave
//                i_busy          - FSM is outside IDLE
//                i_go            - transfer started (clears DONE/ERR)
//                i_done_set      - set DONE
//                i_err_set       - set ERR and DONE
//                i_adv           - one word written: DST++, SRC++ (copy), LEN--
//                o_src/o_dst/o_len/o_fill - current register values
//                o_len_zero      - LEN is zero
//                o_start         - accepted START strobe (only when idle)
//                o_start_fill    - FILL value written with that START
//                o_irq           - completion interrupt
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_dma_copy_regs
    import wb_dma_copy_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       i_s_adr,
    input  logic [31:0]      i_s_dat,
    input  logic             i_s_we,
    input  logic             i_s_stb,
    input  logic             i_s_cyc,
    output logic [31:0]      o_s_dat,
    output logic             o_s_ack,
    input  logic             i_busy,
    input  logic             i_go,
    input  logic             i_done_set,
    input  logic             i_err_set,
    input  logic             i_adv,
    output logic [31:0]      o_src,
    output logic [29:0]      o_dst,
    output logic [LEN_W-1:0] o_len,
    output logic             o_fill,
    output logic             o_len_zero,
    output logic             o_start,
    output logic             o_start_fill,
    output logic             o_irq
);

    logic             r_ack;
    logic [31:0]      r_rdata;
    logic [31:0]      r_src;
    logic [29:0]      r_dst;
    logic [LEN_W-1:0] r_len;
    logic             r_fill;
    logic             r_done;
    logic             r_err;
    logic             w_ie;

    logic             w_req;
    logic             w_wr;
    logic             w_wr_src;
    logic             w_wr_dst;
    logic             w_wr_len;
    logic             w_wr_ctrl;
    logic [31:0]      w_ctrl_rd;
    logic [31:0]      w_rdata;

    // A request is taken only while ack is low, so back-to-back strobes
    // are served every other cycle.
    assign w_req     = i_s_cyc & i_s_stb & ~r_ack;
    assign w_wr      = w_req & i_s_we;
    assign w_wr_src  = w_wr & (i_s_adr == REG_SRC) & ~i_busy;
    assign w_wr_dst  = w_wr & (i_s_adr == REG_DST) & ~i_busy;
    assign w_wr_len  = w_wr & (i_s_adr == REG_LEN) & ~i_busy;
    assign w_wr_ctrl = w_wr & (i_s_adr == REG_CTRL);

    assign o_start      = w_wr_ctrl & i_s_dat[CTRL_START] & ~i_busy;
    assign o_start_fill = i_s_dat[CTRL_FILL];

    always_comb begin
        w_ctrl_rd             = 32'd0;
        w_ctrl_rd[CTRL_FILL]  = r_fill;
        w_ctrl_rd[CTRL_IE]    = w_ie;
        w_ctrl_rd[CTRL_BUSY]  = i_busy;
        w_ctrl_rd[CTRL_DONE]  = r_done;
        w_ctrl_rd[CTRL_ERR]   = r_err;
    end

    always_comb begin
        w_rdata = 32'd0;
        case (i_s_adr)
            REG_SRC:  w_rdata = r_src;
            REG_DST:  w_rdata = {2'b00, r_dst};
            REG_LEN:  w_rdata = {{(32-LEN_W){1'b0}}, r_len};
            REG_CTRL: w_rdata = w_ctrl_rd;
            default:  w_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack   <= 1'b0;
            r_rdata <= 32'd0;
            r_src   <= 32'd0;
            r_dst   <= 30'd0;
            r_len   <= '0;
            r_fill  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ack <= w_req;
            if (w_req) begin
                r_rdata <= w_rdata;
            end

            // Only the address part wraps; bits 31:30 are kept so a copy
            // never disturbs them.
            if (w_wr_src) begin
                r_src <= i_s_dat;
            end else if (i_adv && !r_fill) begin
                r_src <= {r_src[31:30], r_src[29:0] + 30'd1};
            end

            if (w_wr_dst) begin
                r_dst <= i_s_dat[29:0];
            end else if (i_adv) begin
                r_dst <= r_dst + 30'd1;
            end

            if (w_wr_len) begin
                r_len <= i_s_dat[LEN_W-1:0];
            end else if (i_adv) begin
                r_len <= r_len - 1'b1;
            end

            if (w_wr_ctrl && !i_busy) begin
                r_fill <= i_s_dat[CTRL_FILL];
            end

            // Hardware set events take priority over software clears.
            if (i_done_set || i_err_set) begin
                r_done <= 1'b1;
            end else if (i_go || (w_wr_ctrl && i_s_dat[CTRL_DONE])) begin
                r_done <= 1'b0;
            end

            if (i_err_set) begin
                r_err <= 1'b1;
            end else if (i_go || (w_wr_ctrl && i_s_dat[CTRL_ERR])) begin
                r_err <= 1'b0;
            end
        end
    end

`ifdef WB_DMA_COPY_IRQ_EN
    logic r_ie;
    logic r_irq;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ie  <= 1'b0;
            r_irq <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_ie <= i_s_dat[CTRL_IE];
            end
            r_irq <= r_done & r_ie;
        end
    end

    assign w_ie  = r_ie;
    assign o_irq = r_irq;
`else
    assign w_ie  = 1'b0;
    assign o_irq = 1'b0;
`endif

    assign o_s_ack    = r_ack;
    assign o_s_dat    = r_rdata;
    assign o_src      = r_src;
    assign o_dst      = r_dst;
    assign o_len      = r_len;
    assign o_fill     = r_fill;
    assign o_len_zero = (r_len == '0);

endmodule
`default_nettype wire

// File: rtl/wb_dma_copy.sv
`default_nettype none
// ============================================================================
//  Module      : wb_dma_copy
//  Description : Wishbone memory-to-memory DMA engine. Copies LEN words from
//                SRC to DST, or fills LEN words at DST with the SRC pattern,
//                using classic single-transfer cycles with one idle cycle
//                after every acked access.
//  Optional    : WB_DMA_COPY_IRQ_EN enables CTRL.IE and irq_o.
//  Ports       : wb_clk_i, wb_rst_i       - clock, synchronous active-high reset
//                s_adr_i .. s_ack_o       - config slave (4 registers)
//                m_adr_o .. m_ack_i       - bus master port
//                irq_o                    - completion interrupt
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_dma_copy
    import wb_dma_copy_pkg::*;
#(
    parameter int LEN_W = 16,
    parameter int TMO_W = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [1:0]  s_adr_i,
    input  logic [31:0] s_dat_i,
    output logic [31:0] s_dat_o,
    input  logic        s_we_i,
    input  logic        s_stb_i,
    input  logic        s_cyc_i,
    output logic        s_ack_o,
    output logic [29:0] m_adr_o,
    output logic [31:0] m_dat_o,
    input  logic [31:0] m_dat_i,
    output logic        m_we_o,
    output logic [3:0]  m_sel_o,
    output logic        m_stb_o,
    output logic        m_cyc_o,
    input  logic        m_ack_i,
    output logic        irq_o
);

    // Abort fires on the cycle the counter would reach 2^TMO_W-1, so the
    // strobe has then been high for exactly 2^TMO_W-1 cycles.
    localparam logic [TMO_W-1:0] c_tmo_last = {{(TMO_W-1){1'b1}}, 1'b0};

    dma_state_t       r_state;
    dma_state_t       w_state_nxt;
    logic [31:0]      r_buf;
    logic [TMO_W-1:0] r_tmo;

    logic             w_busy;
    logic             w_bus;
    logic             w_go;
    logic             w_done_set;
    logic             w_err_set;
    logic             w_adv;
    logic             w_buf_ld;
    logic             w_tmo_hit;

    logic [31:0]      w_src;
    logic [29:0]      w_dst;
    logic [LEN_W-1:0] w_len;
    logic             w_fill;
    logic             w_len_zero;
    logic             w_start;
    logic             w_start_fill;

    wb_dma_copy_regs #(
        .LEN_W (LEN_W)
    ) u_regs (
        .clk          (wb_clk_i),
        .rst          (wb_rst_i),
        .i_s_adr      (s_adr_i),
        .i_s_dat      (s_dat_i),
        .i_s_we       (s_we_i),
        .i_s_stb      (s_stb_i),
        .i_s_cyc      (s_cyc_i),
        .o_s_dat      (s_dat_o),
        .o_s_ack      (s_ack_o),
        .i_busy       (w_busy),
        .i_go         (w_go),
        .i_done_set   (w_done_set),
        .i_err_set    (w_err_set),
        .i_adv        (w_adv),
        .o_src        (w_src),
        .o_dst        (w_dst),
        .o_len        (w_len),
        .o_fill       (w_fill),
        .o_len_zero   (w_len_zero),
        .o_start      (w_start),
        .o_start_fill (w_start_fill),
        .o_irq        (irq_o)
    );

    assign w_busy    = (r_state != ST_IDLE);
    assign w_bus     = (r_state == ST_RD) || (r_state == ST_WR);
    assign w_tmo_hit = (r_tmo == c_tmo_last);

    // Next-state and event logic
    always_comb begin
        w_state_nxt = r_state;
        w_go        = 1'b0;
        w_done_set  = 1'b0;
        w_err_set   = 1'b0;
        w_adv       = 1'b0;
        w_buf_ld    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    if (w_len_zero) begin
                        w_done_set = 1'b1;
                    end else begin
                        w_go        = 1'b1;
                        w_state_nxt = w_start_fill ? ST_WR : ST_RD;
                    end
                end
            end
            ST_RD: begin
                if (m_ack_i) begin
                    w_buf_ld    = 1'b1;
                    w_state_nxt = ST_RGAP;
                end else if (w_tmo_hit) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RGAP: begin
                w_state_nxt = ST_WR;
            end
            ST_WR: begin
                if (m_ack_i) begin
                    w_adv       = 1'b1;
                    w_state_nxt = ST_WGAP;
                end else if (w_tmo_hit) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WGAP: begin
                // LEN was decremented at the write ack, so it is current here.
                if (w_len_zero) begin
                    w_done_set  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = w_fill ? ST_WR : ST_RD;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Master port outputs; address/data are forced to zero off-bus.
    always_comb begin
        m_cyc_o = w_bus;
        m_stb_o = w_bus;
        m_we_o  = (r_state == ST_WR);
        m_sel_o = 4'hF;
        m_adr_o = 30'd0;
        m_dat_o = 32'd0;
        if (r_state == ST_RD) begin
            m_adr_o = w_src[29:0];
        end else if (r_state == ST_WR) begin
            m_adr_o = w_dst;
            m_dat_o = w_fill ? w_src : r_buf;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
            r_buf   <= 32'd0;
            r_tmo   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_buf_ld) begin
                r_buf <= m_dat_i;
            end
            // Counter is zero on every entry to RD/WR because all other
            // states hold it cleared.
            if (w_bus && !m_ack_i && !w_tmo_hit) begin
                r_tmo <= r_tmo + 1'b1;
            end else begin
                r_tmo <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_dma_copy.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_dma_copy
//  Description : Self-checking bench for wb_dma_copy. A registered-ack RAM
//                model serves the master port; expected bus writes are
//                queued when a transfer is configured and popped as the DUT
//                completes each write.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_dma_copy;
    import wb_dma_copy_pkg::*;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic [1:0]  s_adr_i;
    logic [31:0] s_dat_i;
    logic [31:0] s_dat_o;
    logic        s_we_i;
    logic        s_stb_i;
    logic        s_cyc_i;
    logic        s_ack_o;
    logic [29:0] m_adr_o;
    logic [31:0] m_dat_o;
    logic [31:0] m_dat_i = 32'd0;
    logic        m_we_o;
    logic [3:0]  m_sel_o;
    logic        m_stb_o;
    logic        m_cyc_o;
    logic        m_ack_i = 1'b0;
    logic        irq_o;

    always #5 wb_clk_i = ~wb_clk_i;

    wb_dma_copy dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .s_adr_i  (s_adr_i),
        .s_dat_i  (s_dat_i),
        .s_dat_o  (s_dat_o),
        .s_we_i   (s_we_i),
        .s_stb_i  (s_stb_i),
        .s_cyc_i  (s_cyc_i),
        .s_ack_o  (s_ack_o),
        .m_adr_o  (m_adr_o),
        .m_dat_o  (m_dat_o),
        .m_dat_i  (m_dat_i),
        .m_we_o   (m_we_o),
        .m_sel_o  (m_sel_o),
        .m_stb_o  (m_stb_o),
        .m_cyc_o  (m_cyc_o),
        .m_ack_i  (m_ack_i),
        .irq_o    (irq_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- RAM model (registered ack) ----------------
    logic [31:0] mem [0:4095];
    bit          written [0:4095];
    logic        ram_en = 1'b1;

    function automatic logic [31:0] ram_init(input int unsigned a);
        return 32'hC0DE_0000 ^ (a * 32'h9E37_79B9);
    endfunction

    function automatic logic [31:0] ram_rd(input int unsigned a);
        return written[a] ? mem[a] : ram_init(a);
    endfunction

    always @(posedge wb_clk_i) begin
        m_ack_i <= m_cyc_o & m_stb_o & ~m_ack_i & ram_en;
        if (m_cyc_o && m_stb_o && !m_ack_i && ram_en) begin
            if (m_we_o) begin
                mem[m_adr_o[11:0]]     <= m_dat_o;
                written[m_adr_o[11:0]] <= 1'b1;
            end else begin
                m_dat_i <= ram_rd(int'(m_adr_o[11:0]));
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic [29:0] adr;
        logic [31:0] dat;
    } wr_t;

    wr_t exp_q[$];
    int  n_reads   = 0;
    bit  cyc_seen  = 1'b0;

    // Scoreboard: every acked write must match the head of the queue.
    always @(negedge wb_clk_i) begin
        if (m_cyc_o) cyc_seen = 1'b1;
        if (m_cyc_o && m_stb_o && m_ack_i) begin
            if (m_we_o) begin
                n_tests++;
                assert (exp_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL sb_unexpected_wr: observed adr %h dat %h expected none", m_adr_o, m_dat_o);
                end
                if (exp_q.size() != 0) begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("sb_wr_adr", {2'b00, m_adr_o}, {2'b00, e.adr});
                    chk("sb_wr_dat", m_dat_o, e.dat);
                    chk("sb_wr_sel", {28'd0, m_sel_o}, 32'hF);
                end
            end else begin
                n_reads++;
            end
        end
    end

    // ---------------- config bus tasks ----------------
    task automatic cfg_access(input logic [1:0] a, input logic [31:0] d, input logic we,
                              output logic [31:0] rd);
        int n;
        s_adr_i = a; s_dat_i = d; s_we_i = we; s_cyc_i = 1'b1; s_stb_i = 1'b1;
        n = 0;
        do begin
            @(posedge wb_clk_i); #1;
            n++;
        end while (!s_ack_o && n < 10);
        if (!s_ack_o) chk("s_ack_timeout", {31'd0, s_ack_o}, 32'd1);
        rd = s_dat_o;
        s_cyc_i = 1'b0; s_stb_i = 1'b0; s_we_i = 1'b0;
    endtask

    task automatic cfg_wr(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        cfg_access(a, d, 1'b1, dummy);
    endtask

    task automatic cfg_rd(input logic [1:0] a, output logic [31:0] d);
        cfg_access(a, 32'd0, 1'b0, d);
    endtask

    task automatic wait_done(output logic [31:0] d);
        d = 32'd0;
        for (int k = 0; k < 200; k++) begin
            cfg_rd(REG_CTRL, d);
            if (d[CTRL_DONE]) break;
        end
        if (!d[CTRL_DONE]) chk("done_timeout", d, d | 32'h200);
    endtask

    task automatic push_copy(input int unsigned src, input int unsigned dst, input int len);
        for (int i = 0; i < len; i++) begin
            wr_t e;
            e.adr = 30'(dst + i);
            e.dat = ram_init(src + i);
            exp_q.push_back(e);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] d;
        int n;

        wb_rst_i = 1'b1;
        s_adr_i = 2'd0; s_dat_i = 32'd0; s_we_i = 1'b0; s_stb_i = 1'b0; s_cyc_i = 1'b0;
        repeat (3) @(posedge wb_clk_i);
        #1;
        chk("rst_m_cyc", {31'd0, m_cyc_o}, 32'd0);
        chk("rst_m_stb", {31'd0, m_stb_o}, 32'd0);
        chk("rst_m_we",  {31'd0, m_we_o}, 32'd0);
        chk("rst_m_sel", {28'd0, m_sel_o}, 32'hF);
        chk("rst_m_adr", {2'b00, m_adr_o}, 32'd0);
        chk("rst_m_dat", m_dat_o, 32'd0);
        chk("rst_s_ack", {31'd0, s_ack_o}, 32'd0);
        chk("rst_s_dat", s_dat_o, 32'd0);
        chk("rst_irq",   {31'd0, irq_o}, 32'd0);
        wb_rst_i = 1'b0;
        cfg_rd(REG_CTRL, d); chk("rst_ctrl", d, 32'd0);
        cfg_rd(REG_LEN, d);  chk("rst_len", d, 32'd0);

        // ---- copy 4 words, exact DONE latency ----
        cfg_wr(REG_SRC, 32'h100);
        cfg_wr(REG_DST, 32'h200);
        cfg_wr(REG_LEN, 32'd4);
        push_copy(32'h100, 32'h200, 4);
        cfg_wr(REG_CTRL, 32'h1);
        repeat (23) @(posedge wb_clk_i);
        #1;
        cfg_rd(REG_CTRL, d); chk("copy_ctrl_at_23", d, 32'h100);
        cfg_rd(REG_CTRL, d); chk("copy_ctrl_done",  d, 32'h200);
        cfg_rd(REG_LEN, d);  chk("copy_len_end", d, 32'd0);
        cfg_rd(REG_DST, d);  chk("copy_dst_end", d, 32'h204);
        for (int i = 0; i < 4; i++)
            chk("copy_mem", ram_rd(32'h200 + i), ram_init(32'h100 + i));
        chk("copy_q_empty", exp_q.size(), 32'd0);

        // ---- fill 3 words ----
        cfg_wr(REG_SRC, 32'hDEADBEEF);
        cfg_wr(REG_DST, 32'h10);
        cfg_wr(REG_LEN, 32'd3);
        for (int i = 0; i < 3; i++) begin
            wr_t e;
            e.adr = 30'(32'h10 + i);
            e.dat = 32'hDEADBEEF;
            exp_q.push_back(e);
        end
        n = n_reads;
        cfg_wr(REG_CTRL, 32'h203);
        wait_done(d);
        chk("fill_ctrl_done", d, 32'h202);
        chk("fill_no_reads", n_reads, n);
        for (int i = 0; i < 3; i++)
            chk("fill_mem", ram_rd(32'h10 + i), 32'hDEADBEEF);
        chk("fill_q_empty", exp_q.size(), 32'd0);

        // ---- zero length ----
        cfg_wr(REG_CTRL, 32'h600);
        cfg_rd(REG_CTRL, d); chk("zero_ctrl_clr", d, 32'd0);
        cfg_wr(REG_LEN, 32'd0);
        cyc_seen = 1'b0;
        cfg_wr(REG_CTRL, 32'h1);
        cfg_rd(REG_CTRL, d); chk("zero_ctrl_done", d, 32'h200);
        chk("zero_no_cyc", {31'd0, cyc_seen}, 32'd0);

        // ---- ack timeout ----
        ram_en = 1'b0;
        cfg_wr(REG_SRC, 32'h100);
        cfg_wr(REG_DST, 32'h200);
        cfg_wr(REG_LEN, 32'd2);
        cfg_wr(REG_CTRL, 32'h1);
        n = 0;
        while (m_stb_o && n < 400) begin
            n++;
            @(posedge wb_clk_i); #1;
        end
        chk("tmo_stb_cycles", n, 32'd255);
        chk("tmo_cyc_low", {31'd0, m_cyc_o}, 32'd0);
        cfg_rd(REG_CTRL, d); chk("tmo_ctrl", d, 32'h600);
        cfg_rd(REG_LEN, d);  chk("tmo_len_hold", d, 32'd2);
        ram_en = 1'b1;
        cfg_wr(REG_CTRL, 32'h600);
        cfg_rd(REG_CTRL, d); chk("tmo_ctrl_clr", d, 32'd0);

        // ---- busy protection ----
        cfg_wr(REG_SRC, 32'h300);
        cfg_wr(REG_DST, 32'h400);
        cfg_wr(REG_LEN, 32'd3);
        push_copy(32'h300, 32'h400, 3);
        cfg_wr(REG_CTRL, 32'h1);
        repeat (3) @(posedge wb_clk_i);
        #1;
        cfg_wr(REG_DST, 32'h999);
        cfg_rd(REG_CTRL, d); chk("busy_ctrl", d, 32'h100);
        wait_done(d);
        chk("busy_ctrl_done", d, 32'h200);
        cfg_rd(REG_DST, d); chk("busy_dst_end", d, 32'h403);
        for (int i = 0; i < 3; i++)
            chk("busy_mem", ram_rd(32'h400 + i), ram_init(32'h300 + i));
        chk("busy_mem_999", ram_rd(32'h999), ram_init(32'h999));
        chk("busy_q_empty", exp_q.size(), 32'd0);

        // ---- reset mid-transfer ----
        cfg_wr(REG_SRC, 32'h300);
        cfg_wr(REG_DST, 32'h500);
        cfg_wr(REG_LEN, 32'd3);
        cfg_wr(REG_CTRL, 32'h1);
        chk("mid_cyc_high", {31'd0, m_cyc_o}, 32'd1);
        wb_rst_i = 1'b1;
        @(posedge wb_clk_i); #1;
        chk("mid_rst_cyc", {31'd0, m_cyc_o}, 32'd0);
        chk("mid_rst_stb", {31'd0, m_stb_o}, 32'd0);
        wb_rst_i = 1'b0;
        cfg_rd(REG_SRC, d);  chk("mid_rst_src", d, 32'd0);
        cfg_rd(REG_DST, d);  chk("mid_rst_dst", d, 32'd0);
        cfg_rd(REG_LEN, d);  chk("mid_rst_len", d, 32'd0);
        cfg_rd(REG_CTRL, d); chk("mid_rst_ctrl", d, 32'd0);

        // ---- completion interrupt ----
        cfg_wr(REG_SRC, 32'h20);
        cfg_wr(REG_DST, 32'h30);
        cfg_wr(REG_LEN, 32'd1);
        push_copy(32'h20, 32'h30, 1);
        cfg_wr(REG_CTRL, 32'h5);
        wait_done(d);
`ifdef WB_DMA_COPY_IRQ_EN
        chk("irq_ctrl_done", d, 32'h204);
        @(posedge wb_clk_i); #1;
        chk("irq_set", {31'd0, irq_o}, 32'd1);
        cfg_wr(REG_CTRL, 32'h204);
        @(posedge wb_clk_i); #1;
        chk("irq_clr", {31'd0, irq_o}, 32'd0);
        cfg_rd(REG_CTRL, d); chk("irq_ctrl_ie", d, 32'h004);
`else
        chk("irq_ctrl_done", d, 32'h200);
        @(posedge wb_clk_i); #1;
        chk("irq_tied_low", {31'd0, irq_o}, 32'd0);
`endif
        chk("irq_mem", ram_rd(32'h30), ram_init(32'h20));
        chk("irq_q_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_dma_copy.md
Name: wb_dma_copy

Overview:
- Wishbone memory-to-memory DMA engine. Sits directly upstream of the block-RAM slave and drives its Wishbone port as a bus master.
- Configured by the CPU through a 4-register Wishbone slave port.
- Copies LEN words from SRC to DST, or fills LEN words at DST with a constant.
- Runs classic single-transfer Wishbone cycles, one word at a time.

Parameters:
- LEN_W, 16, width of the word-count register (max transfer is 2^LEN_W-1 words).
- TMO_W, 8, width of the ack-timeout counter; a slave access aborts after 2^TMO_W-1 cycles without ack.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset; synchronous, active-high
- s_adr_i  in  2  config register word select
- s_dat_i  in  32  config write data
- s_dat_o  out  32  config read data
- s_we_i  in  1  config write enable
- s_stb_i  in  1  config strobe
- s_cyc_i  in  1  config cycle
- s_ack_o  out  1  config ack
- m_adr_o  out  30  master word address
- m_dat_o  out  32  master write data
- m_dat_i  in  32  master read data
- m_we_o  out  1  master write enable
- m_sel_o  out  4  byte selects; always 4'hF
- m_stb_o  out  1  master strobe
- m_cyc_o  out  1  master cycle
- m_ack_i  in  1  master ack
- irq_o  out  1  completion interrupt (see Optional Feature)

Behaviour:
- Reset values:
  - All outputs 0, except m_sel_o=4'hF.
  - SRC, DST, LEN and CTRL bits all 0; FSM in IDLE.
- Reset mid-transfer aborts the transfer immediately; any m_cyc_o/m_stb_o drop on the next edge.
- Config slave:
  - s_ack_o is registered: asserted 1 cycle after s_cyc_i&s_stb_i is sampled with s_ack_o=0, held for 1 cycle.
  - Back-to-back strobes are acked every other cycle.
  - Register map:
    - 0: SRC (30b word address, or 32b fill pattern in fill mode).
    - 1: DST (30b word address).
    - 2: LEN (LEN_W bits, zero-extended on read).
    - 3: CTRL.
  - CTRL write bits: bit0 START (self-clearing); bit1 FILL; bit9 writing 1 clears DONE; bit10 writing 1 clears ERR.
  - CTRL read bits: bit1 FILL, bit8 BUSY, bit9 DONE (sticky), bit10 ERR (sticky).
  - Writes to SRC, DST, LEN or FILL while BUSY are ignored; START while BUSY is ignored.
  - Reads are always allowed. LEN reads back the remaining count during a transfer.
- FSM states: IDLE, RD, RGAP, WR, WGAP.
  - IDLE, START=1, LEN=0: set DONE, no bus cycle, stay in IDLE.
  - IDLE, START=1, LEN≠0: set BUSY, clear DONE and ERR, go to RD (copy) or WR (fill).
  - RD: m_cyc_o=m_stb_o=1, m_we_o=0, m_adr_o=SRC. On m_ack_i, latch m_dat_i into the data buffer and go to RGAP.
  - RGAP: cyc/stb=0 for exactly 1 cycle, then WR.
  - WR: cyc/stb=1, we=1, m_adr_o=DST, m_dat_o=buffer (copy) or SRC (fill).
    - On ack: DST+=1; SRC+=1 in copy mode only; LEN-=1. Go to WGAP.
  - WGAP: 1 idle cycle. Then IDLE with DONE=1 and BUSY=0 if LEN=0; otherwise RD (copy) or WR (fill).
- Strobe timing: each strobe stays asserted until ack and drops on the edge after ack is sampled. The mandatory gap cycle keeps the registered-ack RAM from double-acking.
- Throughput with a 1-cycle-ack slave: 3 cycles per access, so copy = 6 cycles/word and fill = 3 cycles/word.
- Addresses wrap modulo 2^30 with no error.
- Timeout:
  - A counter resets at each RD/WR entry and increments each cycle without ack.
  - At 2^TMO_W-1: drop cyc/stb, set ERR and DONE, clear BUSY, go to IDLE. LEN holds the remaining count.
- A config access and an m_ack_i arriving in the same cycle are independent; the slave port never stalls the master FSM.

Optional Feature:
- Macro: WB_DMA_COPY_IRQ_EN.
- Defined:
  - irq_o is a registered level equal to DONE & IE.
  - IE is CTRL bit2, read/write, reset 0.
  - irq_o clears 1 cycle after DONE is cleared.
- Undefined: irq_o tied 0; CTRL bit2 reads 0 and ignores writes.

Decomposition:
- Shared package holds:
  - Register indices REG_SRC=0, REG_DST=1, REG_LEN=2, REG_CTRL=3.
  - CTRL bit positions.
  - FSM state enum.
- One natural sub-module: wb_dma_copy_regs (config slave and register file). The FSM and master port stay in the top module.

Test Plan:
- Copy with a 1-cycle-ack RAM model.
  - Setup: SRC=0x100, DST=0x200, LEN=4, START.
  - Required: RAM[0x200..0x203]==RAM[0x100..0x103]; DONE set 24 cycles after the START ack; LEN reads 0.
- Fill.
  - Setup: SRC=0xDEADBEEF, DST=0x10, LEN=3, FILL=1, START.
  - Required: three writes of 0xDEADBEEF to 0x10..0x12; m_sel_o=4'hF; no read cycles.
- Zero length.
  - Setup: LEN=0, START.
  - Required: DONE=1 on the next CTRL read; m_cyc_o never asserted.
- Timeout.
  - Setup: slave never acks.
  - Required: m_stb_o drops after 255 cycles; ERR=1, DONE=1, BUSY=0.
- Busy protection plus reset.
  - Stimulus: write DST=0x999 mid-transfer, then assert wb_rst_i.
  - Required: DST write ignored and the copy continues; after reset, all registers are 0 and m_cyc_o=0 on the next cycle.
- IRQ.
  - Setup: WB_DMA_COPY_IRQ_EN defined, IE=1, complete a transfer.
  - Required: irq_o=1; write CTRL bit9=1, then irq_o=0 within 1 cycle.
